// File: rtl/regfile_write_scheduler_if.sv
// Write-back bundle between the three producers, decode and the register-file scheduler.
// The master side is the pipeline (producers, allocator, decode); the slave side is the scheduler.
interface regfile_write_scheduler_if;
   logic        m_valid;
   logic        e_valid;
   logic        l_valid;
   logic        m_ready;
   logic        e_ready;
   logic        l_ready;
   logic [3:0]  m_reg;
   logic [3:0]  e_reg;
   logic [3:0]  l_reg;
   logic [31:0] m_value;
   logic [31:0] e_value;
   logic [31:0] l_value;
   logic        alloc_valid;
   logic [3:0]  alloc_reg;
   logic [3:0]  readReg1;
   logic [3:0]  readReg2;
   logic        busy1;
   logic        busy2;
   logic        write1;
   logic        write2;
   logic [3:0]  register1;
   logic [3:0]  register2;
   logic [31:0] value1;
   logic [31:0] value2;

   modport master (
      output m_valid, e_valid, l_valid,
      output m_reg, e_reg, l_reg,
      output m_value, e_value, l_value,
      output alloc_valid, alloc_reg, readReg1, readReg2,
      input  m_ready, e_ready, l_ready,
      input  busy1, busy2,
      input  write1, write2, register1, register2, value1, value2
   );

   modport slave (
      input  m_valid, e_valid, l_valid,
      input  m_reg, e_reg, l_reg,
      input  m_value, e_value, l_value,
      input  alloc_valid, alloc_reg, readReg1, readReg2,
      output m_ready, e_ready, l_ready,
      output busy1, busy2,
      output write1, write2, register1, register2, value1, value2
   );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates M/E/L write-back requests onto two registered register-file write ports and
// tracks which registers still have a write outstanding so decode can stall on them.
module regfile_write_scheduler #(
   parameter int STARVE_LIMIT = 4
) (
   input logic                       clock,
   input logic                       reset,
   regfile_write_scheduler_if.slave  bus
);
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [2:0]  reqValid;
   logic [3:0]  reqReg [3];
   logic [31:0] reqValue [3];

   logic [2:0]  grant;
   logic        p1Valid, p2Valid;
   logic [1:0]  p1Sel, p2Sel;

   logic        write1_q, write2_q;
   logic [3:0]  register1_q, register2_q;
   logic [31:0] value1_q, value2_q;
   logic [14:0] pending_q, pending_d;
   logic [3:0]  starve_q, starve_d;

   logic        lPriority;
   logic [15:0] pendView;

   always_comb begin
      reqValid    = {bus.l_valid, bus.e_valid, bus.m_valid};
      reqReg[0]   = bus.m_reg;
      reqReg[1]   = bus.e_reg;
      reqReg[2]   = bus.l_reg;
      reqValue[0] = bus.m_value;
      reqValue[1] = bus.e_value;
      reqValue[2] = bus.l_value;
   end

   assign lPriority = (starve_q >= LIMIT);

   // Index 0/1/2 = M/E/L. Walk in priority order; a request is granted only while a port is
   // free and its register differs from the one already granted, so a clash defers the later one.
   always_comb begin
      logic [1:0] order [3];
      logic [1:0] src;
      order[0] = lPriority ? 2'd2 : 2'd0;
      order[1] = lPriority ? 2'd0 : 2'd1;
      order[2] = lPriority ? 2'd1 : 2'd2;
      src      = 2'd0;
      grant    = '0;
      p1Valid  = 1'b0;
      p2Valid  = 1'b0;
      p1Sel    = 2'd0;
      p2Sel    = 2'd0;
      for (int k = 0; k < 3; k++) begin
         src = order[k];
         if (!reset && reqValid[src] && reqReg[src] != RNONE) begin
            if (!p1Valid) begin
               grant[src] = 1'b1;
               p1Valid    = 1'b1;
               p1Sel      = src;
            end else if (!p2Valid && reqReg[src] != reqReg[p1Sel]) begin
               grant[src] = 1'b1;
               p2Valid    = 1'b1;
               p2Sel      = src;
            end
         end
      end
   end

   assign bus.m_ready = !reset && reqValid[0] && (reqReg[0] == RNONE || grant[0]);
   assign bus.e_ready = !reset && reqValid[1] && (reqReg[1] == RNONE || grant[1]);
   assign bus.l_ready = !reset && reqValid[2] && (reqReg[2] == RNONE || grant[2]);

   // Clear bits whose write pulse is on the port this cycle, then apply the alloc so set wins.
   always_comb begin
      logic [15:0] pendNext;
      pendNext = {1'b0, pending_q};
      if (write1_q) pendNext[register1_q] = 1'b0;
      if (write2_q) pendNext[register2_q] = 1'b0;
      if (bus.alloc_valid && bus.alloc_reg != RNONE) pendNext[bus.alloc_reg] = 1'b1;
      pending_d = pendNext[14:0];
   end

   always_comb begin
      starve_d = starve_q;
      if (!bus.l_valid || grant[2]) begin
         starve_d = 4'd0;
      end else if (bus.l_reg != RNONE && starve_q < LIMIT) begin
         starve_d = starve_q + 4'd1;
      end
   end

   assign pendView  = {1'b0, pending_q};
   assign bus.busy1 = pendView[bus.readReg1];
   assign bus.busy2 = pendView[bus.readReg2];

   always_ff @(posedge clock) begin
      if (reset) begin
         write1_q    <= 1'b0;
         write2_q    <= 1'b0;
         register1_q <= RNONE;
         register2_q <= RNONE;
         value1_q    <= '0;
         value2_q    <= '0;
         pending_q   <= '0;
         starve_q    <= '0;
      end else begin
         write1_q  <= p1Valid;
         write2_q  <= p2Valid;
         if (p1Valid) begin
            register1_q <= reqReg[p1Sel];
            value1_q    <= reqValue[p1Sel];
         end
         if (p2Valid) begin
            register2_q <= reqReg[p2Sel];
            value2_q    <= reqValue[p2Sel];
         end
         pending_q <= pending_d;
         starve_q  <= starve_d;
      end
   end

   assign bus.write1    = write1_q;
   assign bus.write2    = write2_q;
   assign bus.register1 = register1_q;
   assign bus.register2 = register2_q;
   assign bus.value1    = value1_q;
   assign bus.value2    = value2_q;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed scenarios plus randomized traffic against a reference model of the write-back rules.
module tb_regfile_write_scheduler;
   localparam int LIMIT = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   regfile_write_scheduler_if bus ();

   regfile_write_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Stimulus arrays, index 0/1/2 = M/E/L.
   bit          inV [3];
   logic [3:0]  inR [3];
   logic [31:0] inD [3];
   bit          allocV;
   logic [3:0]  allocR;
   logic [3:0]  rd1, rd2;

   assign bus.m_valid     = inV[0];
   assign bus.e_valid     = inV[1];
   assign bus.l_valid     = inV[2];
   assign bus.m_reg       = inR[0];
   assign bus.e_reg       = inR[1];
   assign bus.l_reg       = inR[2];
   assign bus.m_value     = inD[0];
   assign bus.e_value     = inD[1];
   assign bus.l_value     = inD[2];
   assign bus.alloc_valid = allocV;
   assign bus.alloc_reg   = allocR;
   assign bus.readReg1    = rd1;
   assign bus.readReg2    = rd2;

   // Reference model state.
   bit          mW1, mW2;
   logic [3:0]  mR1, mR2;
   logic [31:0] mV1, mV2;
   bit   [15:0] mPend;
   int          mStarve;
   bit   [2:0]  expRdy;
   int          expG1, expG2;
   bit          expBusy1, expBusy2;

   int   checks = 0;
   int   errors = 0;
   logic [2:0] lastReady;
   logic       lastBusy1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int s, input bit v, input logic [3:0] r, input logic [31:0] d);
      inV[s] = v;
      inR[s] = r;
      inD[s] = d;
   endtask

   task automatic idleAll();
      for (int s = 0; s < 3; s++) applyStimulus(s, 1'b0, 4'hF, 32'd0);
      allocV = 1'b0;
      allocR = 4'hF;
   endtask

   // Priority list first, then hand out at most two ports to distinct registers.
   task automatic modelEval();
      int order [3];
      logic [3:0] taken [$];
      bit clash;
      expRdy = '0;
      expG1  = -1;
      expG2  = -1;
      if (!reset) begin
         if (mStarve >= LIMIT) order = '{2, 0, 1};
         else                  order = '{0, 1, 2};
         for (int k = 0; k < 3; k++) begin
            int s;
            s = order[k];
            if (!inV[s]) continue;
            if (inR[s] == 4'hF) begin
               expRdy[s] = 1'b1;
               continue;
            end
            clash = 1'b0;
            foreach (taken[j]) if (taken[j] == inR[s]) clash = 1'b1;
            if (taken.size() < 2 && !clash) begin
               expRdy[s] = 1'b1;
               taken.push_back(inR[s]);
               if (expG1 < 0) expG1 = s;
               else           expG2 = s;
            end
         end
      end
      expBusy1 = mPend[rd1];
      expBusy2 = mPend[rd2];
   endtask

   task automatic modelStep();
      if (reset) begin
         mW1 = 0; mW2 = 0; mR1 = 4'hF; mR2 = 4'hF; mV1 = 0; mV2 = 0;
         mPend = '0; mStarve = 0;
      end else begin
         if (mW1) mPend[mR1] = 1'b0;
         if (mW2) mPend[mR2] = 1'b0;
         if (allocV && allocR != 4'hF) mPend[allocR] = 1'b1;
         mW1 = (expG1 >= 0);
         mW2 = (expG2 >= 0);
         if (mW1) begin mR1 = inR[expG1]; mV1 = inD[expG1]; end
         if (mW2) begin mR2 = inR[expG2]; mV2 = inD[expG2]; end
         if (!inV[2] || expG1 == 2 || expG2 == 2) mStarve = 0;
         else if (inR[2] != 4'hF && mStarve < LIMIT) mStarve++;
      end
   endtask

   task automatic runCycle();
      @(negedge clock);
      modelEval();
      checkOutput("m_ready", 32'(bus.m_ready), 32'(expRdy[0]));
      checkOutput("e_ready", 32'(bus.e_ready), 32'(expRdy[1]));
      checkOutput("l_ready", 32'(bus.l_ready), 32'(expRdy[2]));
      checkOutput("busy1", 32'(bus.busy1), 32'(expBusy1));
      checkOutput("busy2", 32'(bus.busy2), 32'(expBusy2));
      checkOutput("write1", 32'(bus.write1), 32'(mW1));
      checkOutput("write2", 32'(bus.write2), 32'(mW2));
      checkOutput("register1", 32'(bus.register1), 32'(mR1));
      checkOutput("register2", 32'(bus.register2), 32'(mR2));
      checkOutput("value1", bus.value1, mV1);
      checkOutput("value2", bus.value2, mV2);
      lastReady = {bus.l_ready, bus.e_ready, bus.m_ready};
      lastBusy1 = bus.busy1;
      @(posedge clock);
      modelStep();
      #1;
   endtask

   initial begin
      idleAll();
      rd1 = 4'hF;
      rd2 = 4'hF;
      reset = 1'b1;
      mW1 = 0; mW2 = 0; mR1 = 4'hF; mR2 = 4'hF; mV1 = 0; mV2 = 0; mPend = '0; mStarve = 0;
      @(posedge clock);
      #1;

      // Reset with every producer requesting.
      applyStimulus(0, 1'b1, 4'd1, 32'h1);
      applyStimulus(1, 1'b1, 4'd2, 32'h2);
      applyStimulus(2, 1'b1, 4'd3, 32'h3);
      runCycle();
      runCycle();
      checkOutput("reset_ready", 32'(lastReady), 32'd0);
      reset = 1'b0;
      idleAll();
      runCycle();

      // Dual write; L held off.
      applyStimulus(0, 1'b1, 4'd3, 32'h11);
      applyStimulus(1, 1'b1, 4'd5, 32'h22);
      applyStimulus(2, 1'b1, 4'd6, 32'h66);
      runCycle();
      checkOutput("dual_ready", 32'(lastReady), 32'b011);
      idleAll();
      runCycle();

      // Same-register conflict: M wins, E retries next cycle.
      applyStimulus(0, 1'b1, 4'd4, 32'hAA);
      applyStimulus(1, 1'b1, 4'd4, 32'hBB);
      runCycle();
      checkOutput("conflict_c0", 32'(lastReady), 32'b001);
      applyStimulus(0, 1'b0, 4'hF, 32'd0);
      runCycle();
      checkOutput("conflict_c1", 32'(lastReady), 32'b010);
      idleAll();
      runCycle();
      runCycle();

      // Starvation of L under continuous M/E traffic.
      applyStimulus(0, 1'b1, 4'd1, 32'h11);
      applyStimulus(1, 1'b1, 4'd2, 32'h22);
      applyStimulus(2, 1'b1, 4'd7, 32'h77);
      for (int c = 0; c < 4; c++) runCycle();
      checkOutput("starve_c3", 32'(lastReady), 32'b011);
      runCycle();
      checkOutput("starve_c4", 32'(lastReady), 32'b101);
      applyStimulus(2, 1'b0, 4'hF, 32'd0);
      runCycle();
      idleAll();
      runCycle();
      runCycle();

      // Scoreboard, first without and then with a re-alloc on the write-pulse cycle.
      for (int pass = 0; pass < 2; pass++) begin
         rd1 = 4'd2;
         allocV = 1'b1; allocR = 4'd2;
         runCycle();
         allocV = 1'b0;
         runCycle();
         runCycle();
         applyStimulus(1, 1'b1, 4'd2, 32'h2222);
         runCycle();
         idleAll();
         if (pass == 1) begin allocV = 1'b1; allocR = 4'd2; end
         runCycle();
         allocV = 1'b0;
         runCycle();
         checkOutput("busy_after_write", 32'(lastBusy1), (pass == 1) ? 32'd1 : 32'd0);
         applyStimulus(1, 1'b1, 4'd2, 32'h3333);
         runCycle();
         idleAll();
         runCycle();
         runCycle();
      end

      // RNONE from E with M and L taking both ports.
      applyStimulus(0, 1'b1, 4'd1, 32'h1111);
      applyStimulus(1, 1'b1, 4'hF, 32'hFFFF);
      applyStimulus(2, 1'b1, 4'd2, 32'h2222);
      runCycle();
      checkOutput("rnone_ready", 32'(lastReady), 32'b111);
      idleAll();
      runCycle();

      // Randomized traffic obeying the hold-while-stalled rule.
      for (int c = 0; c < 2000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         for (int s = 0; s < 3; s++) begin
            if (!(inV[s] && !expRdy[s])) begin
               inV[s] = ($urandom_range(0, 99) < 70);
               inR[s] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 7));
               inD[s] = $urandom;
            end
         end
         allocV = ($urandom_range(0, 3) == 0);
         allocR = 4'($urandom_range(0, 15));
         rd1    = 4'($urandom_range(0, 15));
         rd2    = 4'($urandom_range(0, 15));
         runCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
